// File: rtl/lab_access_pkg.sv
// lab_access_pkg: shared types and helpers for the lab access controller.
//   mode_e          - card request mode (exit / enter; 2'b1x means idle)
//   door_state_e    - per-lab door FSM state
//   admit_by_parity - parity-rule admission check above the restriction threshold
package lab_access_pkg;

  typedef enum logic [1:0] {
    MODE_EXIT  = 2'b00,
    MODE_ENTER = 2'b01
  } mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    OPEN = 1'b1
  } door_state_e;

  // pol=1 admits odd-parity codes, pol=0 admits even-parity codes.
  function automatic logic admit_by_parity(input logic [4:0] code, input logic pol);
    return (^code) == pol;
  endfunction

endpackage

// File: rtl/lab_door_ctrl.sv
// lab_door_ctrl: one lab's occupancy counter, full/empty flags, door FSM with unlock timer
// and (with LAB_ACCESS_DENY_CNT_EN defined) a saturating refusal counter.
// Ports:
//   CLK, RSTn        - clock, asynchronous active-low reset
//   reqHit           - request addressed to this lab with an enter/exit mode
//   isEnter          - 1: enter, 0: exit (only meaningful with reqHit)
//   parityOk         - card code satisfies this lab's parity polarity
//   reqReady         - door FSM idle, lab can accept a request
//   count            - registered occupancy
//   isFull / isEmpty - registered flags, consistent with count
//   unlock           - door open
//   restrictionWarn  - one-cycle pulse, parity rule refused admission
//   errUnderflow     - one-cycle pulse, exit on an empty lab
//   denyCnt          - (LAB_ACCESS_DENY_CNT_EN only) saturating refusal count
module lab_door_ctrl
  import lab_access_pkg::*;
#(
  parameter int unsigned CNT_W       = 6,
  parameter int unsigned CAPACITY    = 30,
  parameter int unsigned RESTRICT_TH = 15,
  parameter int unsigned UNLOCK_CYC  = 3
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             reqHit,
  input  logic             isEnter,
  input  logic             parityOk,
  output logic             reqReady,
  output logic [CNT_W-1:0] count,
  output logic             isFull,
  output logic             isEmpty,
  output logic             unlock,
  output logic             restrictionWarn,
  output logic             errUnderflow
`ifdef LAB_ACCESS_DENY_CNT_EN
  ,
  output logic [7:0]       denyCnt
`endif
);

  localparam int unsigned TMR_W = (UNLOCK_CYC > 1) ? $clog2(UNLOCK_CYC) : 1;
  localparam logic [CNT_W-1:0] CapVal  = CNT_W'(CAPACITY);
  localparam logic [CNT_W-1:0] ThVal   = CNT_W'(RESTRICT_TH);
  localparam logic [TMR_W-1:0] TmrLoad = TMR_W'(UNLOCK_CYC - 1);

  door_state_e      state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, empty_q;
  logic             warn_q, warn_d;
  logic             uflow_q, uflow_d;
  logic             accept, doorOpen;

  assign accept = reqHit && (state_q == IDLE);

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    count_d  = count_q;
    warn_d   = 1'b0;
    uflow_d  = 1'b0;
    doorOpen = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (isEnter) begin
            // A full lab refuses silently; the parity rule only applies below capacity.
            if (count_q != CapVal) begin
              if ((count_q < ThVal) || parityOk) begin
                doorOpen = 1'b1;
                count_d  = count_q + 1'b1;
              end else begin
                warn_d = 1'b1;
              end
            end
          end else if (count_q == '0) begin
            uflow_d = 1'b1;
          end else begin
            doorOpen = 1'b1;
            count_d  = count_q - 1'b1;
          end
          if (doorOpen) begin
            state_d = OPEN;
            timer_d = TmrLoad;
          end
        end
      end
      OPEN: begin
        if (timer_q == '0) begin
          state_d = IDLE;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= IDLE;
      timer_q <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      warn_q  <= 1'b0;
      uflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      count_q <= count_d;
      full_q  <= (count_d == CapVal);
      empty_q <= (count_d == '0);
      warn_q  <= warn_d;
      uflow_q <= uflow_d;
    end
  end

`ifdef LAB_ACCESS_DENY_CNT_EN
  logic [7:0] deny_q;
  logic       deny;

  // An accepted enter that does not open the door was refused (full or parity).
  assign deny = accept && (isEnter ? !doorOpen : uflow_d);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      deny_q <= '0;
    end else if (deny && (deny_q != 8'hFF)) begin
      deny_q <= deny_q + 8'd1;
    end
  end

  assign denyCnt = deny_q;
`endif

  assign reqReady        = (state_q == IDLE);
  assign unlock          = (state_q == OPEN);
  assign count           = count_q;
  assign isFull          = full_q;
  assign isEmpty         = empty_q;
  assign restrictionWarn = warn_q;
  assign errUnderflow    = uflow_q;

endmodule

// File: rtl/lab_access_ctrl.sv
// lab_access_ctrl: occupancy and door controller for NUM_LABS labs sharing one card reader.
// Decodes the shared request and fans it out to one lab_door_ctrl per lab.
// Optional feature macro: LAB_ACCESS_DENY_CNT_EN adds the denyCnt output.
// Ports:
//   CLK, RSTn        - clock, asynchronous active-low reset
//   req_valid        - card request present
//   lab_sel          - target lab index (out-of-range indices are ignored)
//   mode             - 00 exit, 01 enter, 1x idle
//   smartCode        - card code
//   parity_pol       - per-lab parity polarity for the restriction rule
//   req_ready        - per-lab ready
//   numOfStu         - packed occupancy, lab i at [i*CNT_W +: CNT_W]
//   isFull, isEmpty  - per-lab occupancy flags
//   unlock           - per-lab door open
//   restrictionWarn  - per-lab parity refusal pulse
//   errUnderflow     - per-lab empty-exit pulse
//   denyCnt          - (LAB_ACCESS_DENY_CNT_EN only) per-lab 8-bit refusal counters
module lab_access_ctrl
  import lab_access_pkg::*;
#(
  parameter int unsigned NUM_LABS    = 2,
  parameter int unsigned CNT_W       = 6,
  parameter int unsigned CAPACITY    = 30,
  parameter int unsigned RESTRICT_TH = 15,
  parameter int unsigned UNLOCK_CYC  = 3,
  parameter int unsigned LAB_W       = (NUM_LABS > 1) ? $clog2(NUM_LABS) : 1
) (
  input  logic                      CLK,
  input  logic                      RSTn,
  input  logic                      req_valid,
  input  logic [LAB_W-1:0]          lab_sel,
  input  logic [1:0]                mode,
  input  logic [4:0]                smartCode,
  input  logic [NUM_LABS-1:0]       parity_pol,
  output logic [NUM_LABS-1:0]       req_ready,
  output logic [NUM_LABS*CNT_W-1:0] numOfStu,
  output logic [NUM_LABS-1:0]       isFull,
  output logic [NUM_LABS-1:0]       isEmpty,
  output logic [NUM_LABS-1:0]       unlock,
  output logic [NUM_LABS-1:0]       restrictionWarn,
  output logic [NUM_LABS-1:0]       errUnderflow
`ifdef LAB_ACCESS_DENY_CNT_EN
  ,
  output logic [NUM_LABS*8-1:0]     denyCnt
`endif
);

  if (RESTRICT_TH > CAPACITY) begin : gen_err_th
    $error("RESTRICT_TH must not exceed CAPACITY");
  end
  if ((CAPACITY >> CNT_W) != 0) begin : gen_err_cap
    $error("CAPACITY must be below 2**CNT_W");
  end
  if (UNLOCK_CYC < 1) begin : gen_err_unlock
    $error("UNLOCK_CYC must be at least 1");
  end

  logic reqActive, isEnter;

  // Mode 1x is idle and never reaches a lab.
  assign reqActive = req_valid && !mode[1];
  assign isEnter   = (mode == MODE_ENTER);

  for (genvar i = 0; i < NUM_LABS; i++) begin : gen_lab
    logic reqHit, parityOk;

    assign reqHit   = reqActive && (lab_sel == LAB_W'(i));
    assign parityOk = admit_by_parity(smartCode, parity_pol[i]);

    lab_door_ctrl #(
      .CNT_W       (CNT_W),
      .CAPACITY    (CAPACITY),
      .RESTRICT_TH (RESTRICT_TH),
      .UNLOCK_CYC  (UNLOCK_CYC)
    ) u_door (
      .CLK             (CLK),
      .RSTn            (RSTn),
      .reqHit          (reqHit),
      .isEnter         (isEnter),
      .parityOk        (parityOk),
      .reqReady        (req_ready[i]),
      .count           (numOfStu[i*CNT_W +: CNT_W]),
      .isFull          (isFull[i]),
      .isEmpty         (isEmpty[i]),
      .unlock          (unlock[i]),
      .restrictionWarn (restrictionWarn[i]),
      .errUnderflow    (errUnderflow[i])
`ifdef LAB_ACCESS_DENY_CNT_EN
      ,
      .denyCnt         (denyCnt[i*8 +: 8])
`endif
    );
  end

endmodule

// File: tb/tb_lab_access_ctrl.sv
// tb_lab_access_ctrl: directed plus randomized checking of lab_access_ctrl against a
// behavioural model (per-lab count, remaining-open cycles, pulses, refusal count).
module tb_lab_access_ctrl;

  localparam int NL  = 2;
  localparam int CW  = 6;
  localparam int CAP = 30;
  localparam int TH  = 15;
  localparam int UC  = 3;
  localparam int LW  = 1;

  logic           CLK = 1'b0;
  logic           RSTn;
  logic           req_valid;
  logic [LW-1:0]  lab_sel;
  logic [1:0]     mode;
  logic [4:0]     smartCode;
  logic [NL-1:0]  parity_pol;
  logic [NL-1:0]  req_ready, isFull, isEmpty, unlock, restrictionWarn, errUnderflow;
  logic [NL*CW-1:0] numOfStu;
`ifdef LAB_ACCESS_DENY_CNT_EN
  logic [NL*8-1:0] denyCnt;
`endif

  lab_access_ctrl #(
    .NUM_LABS    (NL),
    .CNT_W       (CW),
    .CAPACITY    (CAP),
    .RESTRICT_TH (TH),
    .UNLOCK_CYC  (UC),
    .LAB_W       (LW)
  ) dut (
    .CLK             (CLK),
    .RSTn            (RSTn),
    .req_valid       (req_valid),
    .lab_sel         (lab_sel),
    .mode            (mode),
    .smartCode       (smartCode),
    .parity_pol      (parity_pol),
    .req_ready       (req_ready),
    .numOfStu        (numOfStu),
    .isFull          (isFull),
    .isEmpty         (isEmpty),
    .unlock          (unlock),
    .restrictionWarn (restrictionWarn),
    .errUnderflow    (errUnderflow)
`ifdef LAB_ACCESS_DENY_CNT_EN
    ,
    .denyCnt         (denyCnt)
`endif
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  // Model state: occupancy, cycles the door still stays open, pulses, refusals.
  int cnt[NL];
  int rem[NL];
  int deny[NL];
  bit warn[NL];
  bit uf[NL];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NL; i++) begin
      cnt[i] = 0; rem[i] = 0; deny[i] = 0; warn[i] = 0; uf[i] = 0;
    end
  endtask

  // Evaluated at a rising edge with the inputs the DUT sampled there.
  task automatic model_edge();
    for (int i = 0; i < NL; i++) begin
      bit ready;
      ready   = (rem[i] == 0);
      warn[i] = 0;
      uf[i]   = 0;
      if (rem[i] > 0) rem[i]--;
      if (req_valid && (int'(lab_sel) == i) && (mode < 2) && ready) begin
        if (mode == 2'b01) begin
          if (cnt[i] == CAP) begin
            deny[i]++;
          end else if (cnt[i] < TH || (($countones(smartCode) % 2) == int'(parity_pol[i]))) begin
            cnt[i]++;
            rem[i] = UC;
          end else begin
            warn[i] = 1;
            deny[i]++;
          end
        end else if (cnt[i] == 0) begin
          uf[i] = 1;
          deny[i]++;
        end else begin
          cnt[i]--;
          rem[i] = UC;
        end
      end
      if (deny[i] > 255) deny[i] = 255;
    end
  endtask

  task automatic check_outputs(input string tag);
    for (int i = 0; i < NL; i++) begin
      check_eq($sformatf("%s count[%0d]", tag, i), 32'(numOfStu[i*CW +: CW]), cnt[i]);
      check_eq($sformatf("%s isFull[%0d]", tag, i), 32'(isFull[i]), 32'(cnt[i] == CAP));
      check_eq($sformatf("%s isEmpty[%0d]", tag, i), 32'(isEmpty[i]), 32'(cnt[i] == 0));
      check_eq($sformatf("%s unlock[%0d]", tag, i), 32'(unlock[i]), 32'(rem[i] > 0));
      check_eq($sformatf("%s req_ready[%0d]", tag, i), 32'(req_ready[i]), 32'(rem[i] == 0));
      check_eq($sformatf("%s warn[%0d]", tag, i), 32'(restrictionWarn[i]), 32'(warn[i]));
      check_eq($sformatf("%s underflow[%0d]", tag, i), 32'(errUnderflow[i]), 32'(uf[i]));
`ifdef LAB_ACCESS_DENY_CNT_EN
      check_eq($sformatf("%s denyCnt[%0d]", tag, i), 32'(denyCnt[i*8 +: 8]), deny[i]);
`endif
    end
  endtask

  // Drive one cycle of inputs, then check just after the edge that consumes them.
  task automatic apply(input bit v, input int lab, input int md, input int code,
                       input string tag);
    req_valid = v;
    lab_sel   = LW'(lab);
    mode      = 2'(md);
    smartCode = 5'(code);
    @(posedge CLK);
    model_edge();
    #1;
    check_outputs(tag);
  endtask

  task automatic wait_idle(input int lab);
    for (int k = 0; k < 2 * UC + 2 && rem[lab] != 0; k++) apply(0, 0, 3, 0, "wait");
  endtask

  task automatic fill(input int lab, input int target, input int code);
    for (int k = 0; k < 200 && cnt[lab] < target; k++) begin
      wait_idle(lab);
      apply(1, lab, 1, code, "fill");
    end
    wait_idle(lab);
  endtask

  int n_open;

  initial begin
    RSTn       = 1'b0;
    req_valid  = 1'b0;
    lab_sel    = '0;
    mode       = 2'b11;
    smartCode  = '0;
    parity_pol = '0;
    model_reset();
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RSTn = 1'b1;
    #1;
    check_eq("reset numOfStu", 32'(numOfStu), 0);
    check_eq("reset isEmpty", 32'(isEmpty), 3);
    check_eq("reset isFull", 32'(isFull), 0);
    check_eq("reset req_ready", 32'(req_ready), 3);
    check_eq("reset unlock", 32'(unlock), 0);
    @(posedge CLK);
    #1;

    // Underflow on empty lab 1.
    apply(1, 1, 0, 0, "uflow");
    check_eq("uflow pulse", 32'(errUnderflow[1]), 1);
    check_eq("uflow unlock", 32'(unlock[1]), 0);
    check_eq("uflow count", 32'(numOfStu[CW +: CW]), 0);
    apply(0, 0, 3, 0, "uflow_after");
    check_eq("uflow pulse end", 32'(errUnderflow[1]), 0);

    // Single enter on lab 0; further requests while open are ignored.
    apply(1, 0, 1, 5'b00001, "enter");
    n_open = int'(unlock[0]);
    for (int k = 0; k < 2; k++) begin
      apply(1, 0, 1, 5'b00001, "busy");
      n_open += int'(unlock[0]);
    end
    for (int k = 0; k < 3; k++) begin
      apply(0, 0, 3, 0, "close");
      n_open += int'(unlock[0]);
    end
    check_eq("enter count", 32'(numOfStu[0 +: CW]), 1);
    check_eq("unlock cycles", n_open, UC);

    // Parity rule on lab 1 with even polarity.
    parity_pol = 2'b00;
    fill(1, TH, 0);
    check_eq("parity fill", 32'(numOfStu[CW +: CW]), TH);
    apply(1, 1, 1, 5'b00011, "parity_even");
    check_eq("parity even count", 32'(numOfStu[CW +: CW]), 16);
    wait_idle(1);
    apply(1, 1, 1, 5'b00001, "parity_odd");
    check_eq("parity warn", 32'(restrictionWarn[1]), 1);
    check_eq("parity odd count", 32'(numOfStu[CW +: CW]), 16);
    check_eq("parity no unlock", 32'(unlock[1]), 0);
    apply(0, 0, 3, 0, "parity_after");
    check_eq("parity warn end", 32'(restrictionWarn[1]), 0);

    // Capacity on lab 0.
    fill(0, CAP, 0);
    apply(1, 0, 1, 0, "full");
    check_eq("full count", 32'(numOfStu[0 +: CW]), CAP);
    check_eq("full flag", 32'(isFull[0]), 1);
    check_eq("full unlock", 32'(unlock[0]), 0);
    check_eq("full warn", 32'(restrictionWarn[0]), 0);
`ifdef LAB_ACCESS_DENY_CNT_EN
    check_eq("full deny", 32'(denyCnt[0 +: 8]), 1);
`endif

    // Randomized traffic.
    for (int k = 0; k < 800; k++) begin
      int md;
      if ($urandom_range(0, 15) == 0) parity_pol = 2'($urandom);
      md = ($urandom_range(0, 9) < 5) ? 1 : int'($urandom_range(0, 3));
      apply(bit'($urandom_range(0, 3) != 0), int'($urandom_range(0, NL - 1)), md,
            int'($urandom_range(0, 31)), "rand");
    end

    // Asynchronous reset while lab 0 is open.
    wait_idle(0);
    apply(1, 0, (cnt[0] == 0) ? 1 : 0, 0, "pre_reset");
    check_eq("pre_reset unlock", 32'(unlock[0]), 1);
    #2;
    RSTn = 1'b0;
    #1;
    model_reset();
    check_eq("mid reset unlock", 32'(unlock), 0);
    check_eq("mid reset numOfStu", 32'(numOfStu), 0);
    check_eq("mid reset req_ready", 32'(req_ready), 3);
    check_eq("mid reset isEmpty", 32'(isEmpty), 3);
    @(negedge CLK);
    RSTn = 1'b1;
    apply(0, 0, 3, 0, "post_reset");
    apply(1, 1, 1, 5'b00001, "post_reset_enter");
    check_eq("post reset enter", 32'(numOfStu[CW +: CW]), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
